// File: rtl/square_wave_pkg.sv
// Shared types and helpers for the square-wave health monitor.
package square_wave_pkg;

  // Per-channel lock FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sqw_state_e;

  // Width of the consecutive-good-period counter; must hold 0..OK_CYCLES.
  function automatic int good_cnt_w(input int ok_cycles);
    return (ok_cycles < 1) ? 1 : $clog2(ok_cycles + 1);
  endfunction

endpackage

// File: rtl/sqw_chan_monitor.sv
// One monitor channel: 2-FF synchroniser, optional glitch filter, registered
// rising-edge detect, saturating period counter and lock FSM.
// Optional glitch filter is built when GLITCH_FILTER_EN is defined.
module sqw_chan_monitor
  import square_wave_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 12,
  parameter int OK_CYCLES  = 3,
  parameter int FILT_LEN   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic wave_i,
  output logic state_n_o,
  output logic fault_o
);

  localparam int GW = good_cnt_w(OK_CYCLES);
  localparam logic [CNT_W-1:0] MinP     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MaxP     = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] SatP     = CNT_W'(MAX_PERIOD + 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [GW-1:0]    GoodLast = GW'(OK_CYCLES - 1);
  localparam logic [GW-1:0]    GoodOne  = GW'(1);

  logic             sync1_q, sync2_q;
  logic             lvl;
  logic             lvl_prev_q, edge_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    good_cnt_q;
  sqw_state_e       state_q;
  logic             state_n_q, fault_q;
  logic             good, timeout;

  // Two-flop synchroniser; keeps running regardless of enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= wave_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FiltLast = FW'(FILT_LEN - 1);
  localparam logic [FW-1:0] FiltOne  = FW'(1);

  logic          filt_q;
  logic [FW-1:0] stab_q;

  // Follow the synchronised level only after it differs for FILT_LEN cycles in a row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == FiltLast) begin
      filt_q <= sync2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + FiltOne;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // Registered rising-edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_prev_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      lvl_prev_q <= lvl;
      edge_q     <= lvl & ~lvl_prev_q;
    end
  end

  // Period counter next value: restart at 1 on an edge, else count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_q)            cnt_d = CntOne;
    else if (cnt_q != SatP) cnt_d = cnt_q + CntOne;
  end

  assign good    = (cnt_q >= MinP) && (cnt_q <= MaxP);
  assign timeout = (cnt_q == SatP) && !edge_q;

  // Lock FSM with registered status and fault outputs aligned to the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      good_cnt_q <= '0;
      state_n_q  <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (!en_i) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        good_cnt_q <= '0;
        state_n_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
        unique case (state_q)
          ST_IDLE: begin
            if (edge_q) begin
              state_q    <= ST_ACQUIRE;
              good_cnt_q <= '0;
            end
          end
          ST_ACQUIRE: begin
            if (edge_q) begin
              if (!good) begin
                good_cnt_q <= '0;
              end else if (good_cnt_q == GoodLast) begin
                state_q    <= ST_LOCKED;
                good_cnt_q <= '0;
                state_n_q  <= 1'b0;
              end else begin
                good_cnt_q <= good_cnt_q + GoodOne;
              end
            end else if (timeout) begin
              state_q <= ST_IDLE;
            end
          end
          ST_LOCKED: begin
            if (edge_q) begin
              if (!good) begin
                state_q    <= ST_ACQUIRE;
                good_cnt_q <= '0;
                state_n_q  <= 1'b1;
                fault_q    <= 1'b1;
              end
            end else if (timeout) begin
              state_q   <= ST_IDLE;
              state_n_q <= 1'b1;
              fault_q   <= 1'b1;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            state_n_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign state_n_o = state_n_q;
  assign fault_o   = fault_q;

endmodule

// File: rtl/square_wave_monitor.sv
// Multi-channel square-wave health monitor: CH_NUM independent channel
// monitors plus a registered all-channels-locked flag.
// Optional glitch filter is built when GLITCH_FILTER_EN is defined.
module square_wave_monitor
  import square_wave_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 12,
  parameter int OK_CYCLES  = 3,
  parameter int FILT_LEN   = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEnable,
  input  logic [CH_NUM-1:0] isquareWave,
  output logic [CH_NUM-1:0] oState_n,
  output logic [CH_NUM-1:0] oFault,
  output logic              oAllOk_n
);

  logic allok_n_q;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    sqw_chan_monitor #(
      .CNT_W      (CNT_W),
      .MIN_PERIOD (MIN_PERIOD),
      .MAX_PERIOD (MAX_PERIOD),
      .OK_CYCLES  (OK_CYCLES),
      .FILT_LEN   (FILT_LEN)
    ) u_chan (
      .clk_i     (iClk),
      .rst_ni    (iRst_n),
      .en_i      (iEnable),
      .wave_i    (isquareWave[c]),
      .state_n_o (oState_n[c]),
      .fault_o   (oFault[c])
    );
  end

  // Low only when every channel reports locked.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) allok_n_q <= 1'b1;
    else         allok_n_q <= |oState_n;
  end

  assign oAllOk_n = allok_n_q;

endmodule

// File: tb/tb_square_wave_monitor.sv
// Bench for square_wave_monitor (2 channels, no glitch filter): scenario table,
// hand-written corner sequences and a randomized run, all checked every cycle
// against a timestamp-based reference model.
module tb_square_wave_monitor;

  localparam int CH    = 2;
  localparam int MINP  = 8;
  localparam int MAXP  = 12;
  localparam int OKC   = 3;
  localparam int HLEN  = 4096;

  logic          iClk, iRst_n, iEnable;
  logic [CH-1:0] isquareWave, oState_n, oFault;
  logic          oAllOk_n;

  square_wave_monitor #(
    .CH_NUM(CH), .CNT_W(16), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
    .OK_CYCLES(OKC), .FILT_LEN(4)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable), .isquareWave(isquareWave),
    .oState_n(oState_n), .oFault(oFault), .oAllOk_n(oAllOk_n)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int tests, fails;

  // Waveform generator state.
  int per[CH], ph[CH], act[CH], once[CH];
  bit alt[CH], altp[CH], rnd[CH];
  bit en_drv;

  // Reference model state: sampled input history and per-channel lock bookkeeping.
  bit hist[CH][HLEN];
  int n;
  int mst[CH], mg[CH], mlast[CH], last_rise[CH];
  logic [CH-1:0] exp_stn, exp_flt;
  logic exp_allok, prev_any;

  task automatic chk(input string name, input int actv, input int expv);
    tests++;
    if (actv != expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, actv, expv);
    end
  endtask

  function automatic bit wave_bit(input int ch);
    bit b;
    int r;
    if (per[ch] == 0 && !rnd[ch]) begin
      ph[ch] = 0;
      return 1'b0;
    end
    if (ph[ch] == 0) begin
      if (rnd[ch]) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)      act[ch] = int'($urandom_range(MINP, MAXP));
        else if (r < 9) act[ch] = int'($urandom_range(4, 15));
        else            act[ch] = int'($urandom_range(16, 30));
      end else if (once[ch] != 0) begin
        act[ch] = once[ch];
        once[ch] = 0;
      end else if (alt[ch]) begin
        act[ch] = altp[ch] ? 12 : 8;
        altp[ch] = ~altp[ch];
      end else begin
        act[ch] = per[ch];
      end
    end
    b = (ph[ch] < act[ch] / 2);
    ph[ch]++;
    if (ph[ch] >= act[ch]) ph[ch] = 0;
    return b;
  endfunction

  // Model: an input rise sampled at cycle r is acted on at cycle r+3; a period is
  // the distance between two acted-on rises; a timeout is MAX+1 cycles without one.
  task automatic model_update(input bit en);
    bit e;
    int p;
    exp_flt = '0;
    for (int ch = 0; ch < CH; ch++) begin
      e = (n >= 3 && hist[ch][n-3]) && !(n >= 4 && hist[ch][n-4]);
      if (!en) begin
        mst[ch] = 0;
      end else if (mst[ch] == 0) begin
        if (e) begin mst[ch] = 1; mg[ch] = 0; mlast[ch] = n; end
      end else if (e) begin
        p = n - mlast[ch];
        mlast[ch] = n;
        if (p >= MINP && p <= MAXP) begin
          if (mst[ch] == 1) begin
            mg[ch]++;
            if (mg[ch] == OKC) mst[ch] = 2;
          end
        end else begin
          if (mst[ch] == 2) exp_flt[ch] = 1'b1;
          mst[ch] = 1;
          mg[ch] = 0;
        end
      end else if (n - mlast[ch] >= MAXP + 1) begin
        if (mst[ch] == 2) exp_flt[ch] = 1'b1;
        mst[ch] = 0;
      end
      exp_stn[ch] = (mst[ch] != 2);
    end
    exp_allok = prev_any;
    prev_any  = |exp_stn;
  endtask

  task automatic step();
    logic [CH-1:0] v;
    @(negedge iClk);
    for (int ch = 0; ch < CH; ch++) begin
      v[ch] = wave_bit(ch);
      if (n < HLEN) hist[ch][n] = v[ch];
      if (v[ch] && (n == 0 || !hist[ch][n-1])) last_rise[ch] = n;
    end
    isquareWave = v;
    iEnable = en_drv;
    @(posedge iClk);
    #1;
    model_update(en_drv);
    chk("state_n", int'(oState_n), int'(exp_stn));
    chk("fault",   int'(oFault),   int'(exp_flt));
    chk("allok_n", int'(oAllOk_n), int'(exp_allok));
    n++;
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst_n = 1'b0; iEnable = 1'b1; isquareWave = '0;
    @(posedge iClk); #1;
    chk("rst state_n", int'(oState_n), 3);
    chk("rst fault",   int'(oFault),   0);
    chk("rst allok_n", int'(oAllOk_n), 1);
    for (int ch = 0; ch < CH; ch++) begin
      per[ch] = 0; ph[ch] = 0; act[ch] = 0; once[ch] = 0;
      alt[ch] = 0; altp[ch] = 0; rnd[ch] = 0;
      mst[ch] = 0; mg[ch] = 0; mlast[ch] = 0; last_rise[ch] = -1;
      for (int k = 0; k < HLEN; k++) hist[ch][k] = 1'b0;
    end
    prev_any = 1'b1; exp_stn = '1; exp_flt = '0; exp_allok = 1'b1;
    n = 0; en_drv = 1'b1;
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  typedef struct {
    int         p0, p1, ncyc;
    logic [1:0] stn;
    logic       allok;
    bit         fault_seen;
  } vec_t;

  vec_t vt[6];
  int first_lock, fault_n, fcnt;
  bit seen, seen2;

  initial begin
    tests = 0; fails = 0; n = 0;
    iRst_n = 1'b0; iEnable = 1'b1; isquareWave = '0; en_drv = 1'b1;

    vt[0] = '{p0:10, p1:0,  ncyc:120, stn:2'b10, allok:1'b1, fault_seen:1'b0};
    vt[1] = '{p0:10, p1:10, ncyc:120, stn:2'b00, allok:1'b0, fault_seen:1'b0};
    vt[2] = '{p0:7,  p1:13, ncyc:200, stn:2'b11, allok:1'b1, fault_seen:1'b0};
    vt[3] = '{p0:8,  p1:12, ncyc:120, stn:2'b00, allok:1'b0, fault_seen:1'b0};
    vt[4] = '{p0:12, p1:9,  ncyc:150, stn:2'b00, allok:1'b0, fault_seen:1'b0};
    vt[5] = '{p0:14, p1:6,  ncyc:200, stn:2'b11, allok:1'b1, fault_seen:1'b0};

    // Scenario table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      per[0] = vt[i].p0; per[1] = vt[i].p1;
      seen = 1'b0;
      for (int c = 0; c < vt[i].ncyc; c++) begin
        step();
        if (oFault != '0) seen = 1'b1;
      end
      chk($sformatf("vec%0d state_n", i), int'(oState_n), int'(vt[i].stn));
      chk($sformatf("vec%0d allok_n", i), int'(oAllOk_n), int'(vt[i].allok));
      chk($sformatf("vec%0d fault_seen", i), int'(seen), int'(vt[i].fault_seen));
    end

    // Lock latency: first rise sampled at cycle 0, 4th rise at 30, locked after cycle 33.
    do_reset();
    per[0] = 10;
    first_lock = -1; seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (first_lock < 0 && !oState_n[0]) first_lock = n - 1;
      if (!oAllOk_n) seen = 1'b1;
    end
    chk("lock latency", first_lock, 33);
    chk("allok stays high", int'(seen), 0);

    // Loss of edges while locked: timeout 16 cycles after the last sampled rise.
    do_reset();
    per[0] = 10;
    for (int c = 0; c < 60; c++) step();
    chk("pre-timeout locked", int'(oState_n[0]), 0);
    per[0] = 0;
    fault_n = -1; fcnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (oFault[0]) begin fcnt++; if (fault_n < 0) fault_n = n - 1; end
    end
    chk("timeout fault count", fcnt, 1);
    chk("timeout delay", fault_n - last_rise[0], 16);
    chk("timeout state_n", int'(oState_n[0]), 1);

    // Alternating 8/12 periods lock; period 7 never does.
    do_reset();
    alt[0] = 1'b1; per[0] = 1; per[1] = 7;
    seen = 1'b0;
    for (int c = 0; c < 150; c++) begin
      step();
      if (oFault != '0) seen = 1'b1;
    end
    chk("alt 8/12 state_n", int'(oState_n), 2'b10);
    chk("alt no fault", int'(seen), 0);

    // One long period on ch1 while both locked: fault, then relock.
    do_reset();
    per[0] = 10; per[1] = 10;
    for (int c = 0; c < 80; c++) step();
    chk("both locked allok", int'(oAllOk_n), 0);
    once[1] = 13;
    fcnt = 0; seen = 1'b0; seen2 = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      if (oFault[1]) fcnt++;
      if (oFault[0]) seen2 = 1'b1;
      if (oAllOk_n) seen = 1'b1;
    end
    chk("ch1 fault count", fcnt, 1);
    chk("ch0 no fault", int'(seen2), 0);
    chk("allok went high", int'(seen), 1);
    chk("relock allok", int'(oAllOk_n), 0);

    // Enable drop while locked: immediate idle, no fault, then relock.
    en_drv = 1'b0;
    step();
    chk("disable state_n", int'(oState_n), 3);
    chk("disable fault", int'(oFault), 0);
    for (int c = 0; c < 4; c++) step();
    en_drv = 1'b1;
    for (int c = 0; c < 60; c++) step();
    chk("re-enable relock", int'(oState_n), 0);

    // Asynchronous reset mid-lock, checked before any clock edge.
    chk("pre-reset locked", int'(oState_n), 0);
    #2 iRst_n = 1'b0;
    #1;
    chk("async rst state_n", int'(oState_n), 3);
    chk("async rst fault", int'(oFault), 0);
    chk("async rst allok_n", int'(oAllOk_n), 1);

    // Randomized periods and enable drops against the model.
    do_reset();
    rnd[0] = 1'b1; rnd[1] = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      en_drv = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
